// File: rtl/maquina_estados_mascota_pkg.sv
// Shared pet-state codes, need priority order and level bundle for the pet behaviour FSM.
// Latency: none (types and pure functions only); backpressure: not applicable.
package maquina_estados_mascota_pkg;

  typedef enum logic [2:0] {
    NEUTRO     = 3'd0,
    FELIZ      = 3'd1,
    HAMBRIENTO = 3'd2,
    CANSADO    = 3'd3,
    TRISTE     = 3'd4,
    ENFERMO    = 3'd5
  } estado_t;

  typedef struct packed {
    logic [1:0] animo;
    logic [1:0] energia;
    logic [1:0] descanso;
    logic [1:0] medicina;
  } niveles_t;

  localparam logic [2:0] PRIO_NINGUNA    = 3'd0;
  localparam logic [2:0] PRIO_TRISTE     = 3'd1;
  localparam logic [2:0] PRIO_CANSADO    = 3'd2;
  localparam logic [2:0] PRIO_HAMBRIENTO = 3'd3;
  localparam logic [2:0] PRIO_ENFERMO    = 3'd4;

  localparam logic [2:0] CODIGO_TEST_PRIMERO = 3'd1;
  localparam logic [2:0] CODIGO_TEST_ULTIMO  = 3'd5;

  function automatic logic [2:0] prioridad(input estado_t s);
    case (s)
      ENFERMO:    return PRIO_ENFERMO;
      HAMBRIENTO: return PRIO_HAMBRIENTO;
      CANSADO:    return PRIO_CANSADO;
      TRISTE:     return PRIO_TRISTE;
      default:    return PRIO_NINGUNA;
    endcase
  endfunction

  // Highest-priority need currently at or below the entry threshold, NEUTRO if none.
  function automatic estado_t necesidad(input niveles_t n, input logic [1:0] bajo);
    if (n.medicina <= bajo)      return ENFERMO;
    else if (n.energia <= bajo)  return HAMBRIENTO;
    else if (n.descanso <= bajo) return CANSADO;
    else if (n.animo <= bajo)    return TRISTE;
    else                         return NEUTRO;
  endfunction

  function automatic logic [1:0] nivel_propio(input estado_t s, input niveles_t n);
    case (s)
      ENFERMO:    return n.medicina;
      HAMBRIENTO: return n.energia;
      CANSADO:    return n.descanso;
      TRISTE:     return n.animo;
      default:    return 2'd3;
    endcase
  endfunction

  function automatic logic [2:0] codigo_test_siguiente(input logic [2:0] c);
    return (c == CODIGO_TEST_ULTIMO) ? CODIGO_TEST_PRIMERO : c + 3'd1;
  endfunction

endpackage

// File: rtl/maquina_estados_mascota_if.sv
// Level/test inputs and state/enable outputs between the mode block (master) and the pet FSM (slave).
// Latency: wires only; backpressure: none, levels are sampled every clk.
interface maquina_estados_mascota_if;
  logic       B_Test;
  logic [1:0] Nivel_Animo;
  logic [1:0] Nivel_Energia;
  logic [1:0] Nivel_Descanso;
  logic [1:0] Nivel_Medicina;
  logic       Activo_Comida;
  logic       Activo_Medicina;
  logic [2:0] Estado;
  logic       Test_Activo;

  modport master (
    output B_Test, Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina,
    input  Activo_Comida, Activo_Medicina, Estado, Test_Activo
  );

  modport slave (
    input  B_Test, Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina,
    output Activo_Comida, Activo_Medicina, Estado, Test_Activo
  );
endinterface

// File: rtl/maquina_estados_mascota_contador_test.sv
// Free-running tick counter: tick is high for 1 clk every TEST_TICKS enabled clks.
// Latency: tick is combinational from the count; backpressure: none, clear wins over enable.
module contador_test #(
  parameter int TEST_TICKS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int ANCHO = (TEST_TICKS > 1) ? $clog2(TEST_TICKS) : 1;
  localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(TEST_TICKS - 1);

  logic [ANCHO-1:0] cuenta_q;

  assign tick = enable && (cuenta_q == ULTIMO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cuenta_q <= '0;
    end else if (clear) begin
      cuenta_q <= '0;
    end else if (enable) begin
      cuenta_q <= tick ? '0 : cuenta_q + 1'b1;
    end
  end

endmodule

// File: rtl/maquina_estados_mascota.sv
// Pet behaviour FSM with hysteretic need states and a display self-test; all outputs registered.
// Latency: 1 clk from sampled level/B_Test to outputs; backpressure: none.
module maquina_estados_mascota
  import maquina_estados_mascota_pkg::*;
#(
  parameter logic [1:0] UMBRAL_BAJO = 2'd0,
  parameter logic [1:0] UMBRAL_ALTO = 2'd2,
  parameter int         TEST_TICKS  = 10
) (
  input logic                     clk,
  input logic                     reset,
  maquina_estados_mascota_if.slave bus
);

  niveles_t   niveles;
  estado_t    estado_q;
  estado_t    estado_d;
  estado_t    necesidad_act;
  logic [2:0] codigo_q;
  logic       comida_q;
  logic       medicina_q;
  logic       test_q;
  logic       tick_test;

  assign niveles       = {bus.Nivel_Animo, bus.Nivel_Energia, bus.Nivel_Descanso, bus.Nivel_Medicina};
  assign necesidad_act = necesidad(niveles, UMBRAL_BAJO);

  contador_test #(.TEST_TICKS(TEST_TICKS)) u_contador_test (
    .clk    (clk),
    .reset  (reset),
    .clear  (bus.B_Test),
    .enable (test_q && !bus.B_Test),
    .tick   (tick_test)
  );

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      NEUTRO, FELIZ: begin
        if (necesidad_act != NEUTRO) estado_d = necesidad_act;
        else if (niveles == '1)      estado_d = FELIZ;
        else                         estado_d = NEUTRO;
      end
      default: begin
        // Only a strictly higher need preempts; exit goes through NEUTRO for re-evaluation.
        if (prioridad(necesidad_act) > prioridad(estado_q))
          estado_d = necesidad_act;
        else if (nivel_propio(estado_q, niveles) >= UMBRAL_ALTO)
          estado_d = NEUTRO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= NEUTRO;
      codigo_q   <= 3'd0;
      comida_q   <= 1'b0;
      medicina_q <= 1'b0;
      test_q     <= 1'b0;
    end else if (bus.B_Test) begin
      // The test toggle takes the whole cycle; the FSM stays frozen until the next one.
      if (test_q) begin
        test_q     <= 1'b0;
        codigo_q   <= estado_q;
        comida_q   <= (estado_q == HAMBRIENTO);
        medicina_q <= (estado_q == ENFERMO);
      end else begin
        test_q     <= 1'b1;
        codigo_q   <= CODIGO_TEST_PRIMERO;
        comida_q   <= 1'b0;
        medicina_q <= 1'b0;
      end
    end else if (test_q) begin
      if (tick_test) codigo_q <= codigo_test_siguiente(codigo_q);
    end else begin
      estado_q   <= estado_d;
      codigo_q   <= estado_d;
      comida_q   <= (estado_d == HAMBRIENTO);
      medicina_q <= (estado_d == ENFERMO);
    end
  end

  assign bus.Estado          = codigo_q;
  assign bus.Activo_Comida   = comida_q;
  assign bus.Activo_Medicina = medicina_q;
  assign bus.Test_Activo     = test_q;

endmodule
